// File: rtl/fpv_pkg.sv
// Shared constants and FSM state type for the first-person-view column renderer.
package fpv_pkg;
    localparam int CH_W         = 6;
    localparam int COLOUR_W     = 3 * CH_W;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;

    localparam logic [COLOUR_W-1:0] DEF_CEIL_COL  = 18'h0F3CF;
    localparam logic [COLOUR_W-1:0] DEF_FLOOR_COL = 18'h14514;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAW,
        ST_FIN
    } fpv_state_e;
endpackage

// File: rtl/fpv_shade.sv
// Halves every channel of a packed RGB word when shading is enabled and the wall side is the dark one.
module fpv_shade #(
    parameter int CH_W     = 6,
    parameter bit SHADE_EN = 1'b1
) (
    input  logic [3*CH_W-1:0] colour_i,
    input  logic              side_i,
    output logic [3*CH_W-1:0] colour_o
);
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            assign colour_o[gi*CH_W +: CH_W] = (SHADE_EN && side_i)
                ? {1'b0, colour_i[gi*CH_W+1 +: CH_W-1]}
                : colour_i[gi*CH_W +: CH_W];
        end
    endgenerate
endmodule

// File: rtl/draw_fpv_cols.sv
// Column renderer: requests one wall slice per screen column, then streams
// ceiling / wall / floor pixels for that column top-to-bottom.
module draw_fpv_cols #(
    parameter int                     SCREEN_W  = fpv_pkg::DEF_SCREEN_W,
    parameter int                     SCREEN_H  = fpv_pkg::DEF_SCREEN_H,
    parameter int                     X_W       = fpv_pkg::DEF_X_W,
    parameter int                     Y_W       = fpv_pkg::DEF_Y_W,
    parameter int                     CH_W      = fpv_pkg::CH_W,
    parameter bit                     SHADE_EN  = 1'b1,
    parameter logic [3*CH_W-1:0]      CEIL_COL  = fpv_pkg::DEF_CEIL_COL,
    parameter logic [3*CH_W-1:0]      FLOOR_COL = fpv_pkg::DEF_FLOOR_COL
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                done,
    output logic                col_req,
    output logic [X_W-1:0]      col_x,
    input  logic                col_ack,
    input  logic [Y_W:0]        col_height,
    input  logic                col_side,
    input  logic [3*CH_W-1:0]   col_colour,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [3*CH_W-1:0]   vga_colour,
    output logic                vga_write
);
    import fpv_pkg::*;

    localparam int                CW     = 3 * CH_W;
    localparam int                HW     = Y_W + 1;
    localparam logic [HW-1:0]     H_MAX  = HW'(SCREEN_H);
    localparam logic [X_W-1:0]    X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0]    Y_LAST = Y_W'(SCREEN_H - 1);

    fpv_state_e      state_q, state_d;
    logic [X_W-1:0]  col_x_q, col_x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic [HW-1:0]   top_q, top_d, bot_q, bot_d;
    logic [CW-1:0]   wall_q, wall_d;
    logic            col_req_q, col_req_d;
    logic            done_q, done_d;
    logic            vga_write_q, vga_write_d;
    logic [X_W-1:0]  vga_x_q, vga_x_d;
    logic [Y_W-1:0]  vga_y_q, vga_y_d;
    logic [CW-1:0]   vga_colour_q, vga_colour_d;

    logic [CW-1:0]   shaded;
    logic [HW-1:0]   h_clamp, top_calc, y_ext;

    fpv_shade #(.CH_W(CH_W), .SHADE_EN(SHADE_EN)) u_shade (
        .colour_i (col_colour),
        .side_i   (col_side),
        .colour_o (shaded)
    );

    // Slice is centred; an odd leftover row lands below the wall (floor side).
    assign h_clamp  = (col_height > H_MAX) ? H_MAX : col_height;
    assign top_calc = (H_MAX - h_clamp) >> 1;
    assign y_ext    = {1'b0, y_q};

    always_comb begin
        state_d      = state_q;
        col_x_d      = col_x_q;
        y_d          = y_q;
        top_d        = top_q;
        bot_d        = bot_q;
        wall_d       = wall_q;
        col_req_d    = col_req_q;
        done_d       = 1'b0;
        vga_write_d  = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_REQ;
                    col_x_d   = '0;
                    col_req_d = 1'b1;
                end
            end
            ST_REQ, ST_WAIT: begin
                state_d = ST_WAIT;
                if (col_ack) begin
                    top_d     = top_calc;
                    bot_d     = top_calc + h_clamp;
                    wall_d    = shaded;
                    col_req_d = 1'b0;
                    y_d       = '0;
                    state_d   = ST_DRAW;
                end
            end
            ST_DRAW: begin
                vga_write_d = 1'b1;
                vga_x_d     = col_x_q;
                vga_y_d     = y_q;
                if (y_ext < top_q)
                    vga_colour_d = CEIL_COL;
                else if (y_ext < bot_q)
                    vga_colour_d = wall_q;
                else
                    vga_colour_d = FLOOR_COL;

                if (y_q == Y_LAST) begin
                    if (col_x_q == X_LAST) begin
                        state_d = ST_FIN;
                    end else begin
                        col_x_d   = col_x_q + 1'b1;
                        col_req_d = 1'b1;
                        state_d   = ST_REQ;
                    end
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            col_x_q      <= '0;
            y_q          <= '0;
            top_q        <= '0;
            bot_q        <= '0;
            wall_q       <= '0;
            col_req_q    <= 1'b0;
            done_q       <= 1'b0;
            vga_write_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            col_x_q      <= col_x_d;
            y_q          <= y_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            wall_q       <= wall_d;
            col_req_q    <= col_req_d;
            done_q       <= done_d;
            vga_write_q  <= vga_write_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
        end
    end

    assign done       = done_q;
    assign col_req    = col_req_q;
    assign col_x      = col_x_q;
    assign vga_write  = vga_write_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
endmodule

// File: tb/tb_draw_fpv_cols.sv
// Scoreboard bench for draw_fpv_cols: a random raycaster pushes expected pixels, monitors pop and compare.
module tb_draw_fpv_cols;
    localparam logic [17:0] CEIL  = 18'h0F3CF;
    localparam logic [17:0] FLOOR = 18'h14514;

    typedef struct {
        int          x;
        int          y;
        logic [17:0] c;
    } pix_t;

    logic clk;
    logic reset, start, s_start;

    // default-geometry DUT
    logic        done, col_req, col_ack, col_side, vga_write;
    logic [7:0]  col_x, col_height, vga_x;
    logic [6:0]  vga_y;
    logic [17:0] col_colour, vga_colour;

    // small-geometry DUT (4 x 7)
    logic        s_done, s_req, s_ack, s_side, s_write;
    logic [1:0]  s_col_x, s_vga_x;
    logic [3:0]  s_height;
    logic [2:0]  s_vga_y;
    logic [17:0] s_colour, s_vga_colour;

    int checks = 0;
    int passes = 0;
    pix_t exp_q[$];
    pix_t s_exp_q[$];
    int frame_pix = 0, done_cnt = 0, s_frame_pix = 0, s_done_cnt = 0;
    int resp_col = 0, lat = 0, s_col = 0;
    bit waiting = 0, spur_en = 0;

    draw_fpv_cols dut (
        .clock(clk), .reset(reset), .start(start), .done(done),
        .col_req(col_req), .col_x(col_x), .col_ack(col_ack),
        .col_height(col_height), .col_side(col_side), .col_colour(col_colour),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
    );

    draw_fpv_cols #(.SCREEN_W(4), .SCREEN_H(7), .X_W(2), .Y_W(3)) dut_s (
        .clock(clk), .reset(reset), .start(s_start), .done(s_done),
        .col_req(s_req), .col_x(s_col_x), .col_ack(s_ack),
        .col_height(s_height), .col_side(s_side), .col_colour(s_colour),
        .vga_x(s_vga_x), .vga_y(s_vga_y), .vga_colour(s_vga_colour), .vga_write(s_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference pixel: centred clamped slice, ceiling above, floor below, halved channels on side 1.
    function automatic logic [17:0] model_pix(int scr_h, int h_raw, bit side, logic [17:0] c, int y);
        int h, top;
        logic [17:0] wall;
        h    = (h_raw > scr_h) ? scr_h : h_raw;
        top  = (scr_h - h) / 2;
        wall = side ? {c[17:12] / 6'd2, c[11:6] / 6'd2, c[5:0] / 6'd2} : c;
        if (y < top)          return CEIL;
        else if (y < top + h) return wall;
        else                  return FLOOR;
    endfunction

    // Raycaster model for the default DUT: special slices on columns 0..4, random elsewhere.
    always @(negedge clk) begin
        if (reset) begin
            col_ack  = 1'b0;
            resp_col = 0;
            waiting  = 1'b0;
        end else if (col_req && !col_ack) begin
            if (!waiting) begin
                waiting = 1'b1;
                lat     = (resp_col == 4) ? 5 : int'($urandom_range(0, 2));
                chk("col_x_at_req", 32'(col_x), 32'(resp_col));
            end
            if (lat == 0) begin
                case (resp_col)
                    0: begin col_height = 8'd40;  col_side = 1'b0; col_colour = 18'h3F000; end
                    1: begin col_height = 8'd200; col_side = 1'b1; col_colour = 18'h3FFFF; end
                    2: begin col_height = 8'd0;   col_side = 1'(
                              $urandom_range(0, 1)); col_colour = 18'($urandom); end
                    3: begin col_height = 8'd1;   col_side = 1'b1; col_colour = 18'($urandom); end
                    4: begin col_height = 8'd120; col_side = 1'b0; col_colour = 18'($urandom); end
                    default: begin
                        col_height = 8'($urandom_range(0, 255));
                        col_side   = 1'($urandom_range(0, 1));
                        col_colour = 18'($urandom);
                    end
                endcase
                for (int yy = 0; yy < 120; yy++) begin
                    pix_t e;
                    e.x = resp_col;
                    e.y = yy;
                    e.c = model_pix(120, int'(col_height), col_side, col_colour, yy);
                    exp_q.push_back(e);
                end
                col_ack  = 1'b1;
                waiting  = 1'b0;
                resp_col = (resp_col + 1) % 160;
            end else begin
                lat--;
            end
        end else if (!col_req) begin
            col_ack = spur_en;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            s_ack = 1'b0;
            s_col = 0;
        end else if (s_req && !s_ack) begin
            s_height = 4'd2;
            s_side   = 1'($urandom_range(0, 1));
            s_colour = 18'($urandom);
            chk("s_col_x_at_req", 32'(s_col_x), 32'(s_col));
            for (int yy = 0; yy < 7; yy++) begin
                pix_t e;
                e.x = s_col;
                e.y = yy;
                e.c = model_pix(7, 2, s_side, s_colour, yy);
                s_exp_q.push_back(e);
            end
            s_ack = 1'b1;
            s_col = (s_col + 1) % 4;
        end else if (!s_req) begin
            s_ack = 1'b0;
        end
    end

    // Monitors: every write must match the oldest expected pixel; done must close a complete frame.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            frame_pix = 0;
        end else begin
            if (vga_write) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d expected no write", vga_x, vga_y);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pix_x", 32'(vga_x), 32'(e.x));
                    chk("pix_y", 32'(vga_y), 32'(e.y));
                    chk("pix_colour", 32'(vga_colour), 32'(e.c));
                end
                frame_pix++;
            end
            if (done) begin
                chk("frame_pixels_at_done", 32'(frame_pix), 32'(160 * 120));
                chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
                done_cnt++;
                frame_pix = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            s_exp_q.delete();
            s_frame_pix = 0;
        end else begin
            if (s_write) begin
                if (s_exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL s_unexpected_write: got x=%0d y=%0d expected no write", s_vga_x, s_vga_y);
                end else begin
                    pix_t e;
                    e = s_exp_q.pop_front();
                    chk("s_pix_x", 32'(s_vga_x), 32'(e.x));
                    chk("s_pix_y", 32'(s_vga_y), 32'(e.y));
                    chk("s_pix_colour", 32'(s_vga_colour), 32'(e.c));
                end
                s_frame_pix++;
            end
            if (s_done) begin
                chk("s_frame_pixels_at_done", 32'(s_frame_pix), 32'd28);
                s_done_cnt++;
                s_frame_pix = 0;
            end
        end
    end

    initial begin
        int n;
        reset   = 1'b1;
        start   = 1'b0;
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_col_req", 32'(col_req), 32'd0);
        chk("rst_col_x", 32'(col_x), 32'd0);
        chk("rst_vga_write", 32'(vga_write), 32'd0);
        chk("rst_vga_x", 32'(vga_x), 32'd0);
        chk("rst_vga_y", 32'(vga_y), 32'd0);
        chk("rst_vga_colour", 32'(vga_colour), 32'd0);
        reset = 1'b0;

        // stray acks while idle must be ignored
        spur_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ack_col_req", 32'(col_req), 32'd0);
            chk("idle_ack_write", 32'(vga_write), 32'd0);
        end
        spur_en = 1'b0;
        @(negedge clk);

        // frame 1: single start pulse, re-pulse during DRAW must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("req_after_start", 32'(col_req), 32'd1);
        n = 0;
        while (!(vga_write && vga_x == 8'd10) && n < 20000) begin @(negedge clk); n++; end
        chk("reach_col10", 32'(n < 20000), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 30000) begin @(negedge clk); n++; end
        chk("frame1_done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("done_count_f1", 32'(done_cnt), 32'd1);
        repeat (3) begin
            chk("no_relaunch", 32'(col_req), 32'd0);
            @(negedge clk);
        end

        // frame 2: start held, reset at column 37 row 10
        start = 1'b1;
        n = 0;
        while (!(vga_write && vga_x == 8'd37 && vga_y == 7'd10) && n < 10000) begin @(negedge clk); n++; end
        chk("reach_col37_row10", 32'(n < 10000), 32'd1);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("midrst_write", 32'(vga_write), 32'd0);
        chk("midrst_col_req", 32'(col_req), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle_req", 32'(col_req), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
        end

        // frame 3: start held through FIN re-launches exactly once per IDLE entry
        start = 1'b1;
        n = 0;
        while (!done && n < 30000) begin @(negedge clk); n++; end
        chk("frame3_done_seen", 32'(done), 32'd1);
        @(negedge clk);
        chk("held_start_relaunch", 32'(col_req), 32'd1);
        chk("done_count_f3", 32'(done_cnt), 32'd2);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // small geometry frame
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        n = 0;
        while (!s_done && n < 200) begin @(negedge clk); n++; end
        chk("s_done_seen", 32'(s_done), 32'd1);
        @(negedge clk);
        chk("s_done_count", 32'(s_done_cnt), 32'd1);
        chk("s_no_relaunch", 32'(s_req), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
